// File: rtl/diagnosis_argmax.sv
// Argmax over one frame of signed class scores, reporting the winner, the runner-up and a confidence margin.
// One score is examined per enabled cycle; results are held until the consumer accepts them.
module diagnosis_argmax #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CLASSES = 15,
    parameter int IDX_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] LOW_CONF_MARGIN = 16'h0040
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_in,
    input  logic                              scores_valid,
    input  logic                              result_ready,
    output logic                              result_valid,
    output logic [IDX_WIDTH-1:0]              class_idx,
    output logic signed [DATA_WIDTH-1:0]      max_score,
    output logic [IDX_WIDTH-1:0]              second_idx,
    output logic [DATA_WIDTH-1:0]             margin,
    output logic                              low_conf,
    output logic                              busy,
    output logic [7:0]                        drop_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [IDX_WIDTH-1:0] LAST_K = IDX_WIDTH'(NUM_CLASSES - 1);

    logic [1:0]                        state_q, state_d;
    logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_q, scores_d;
    logic signed [DATA_WIDTH-1:0]      max_q, max_d;
    logic signed [DATA_WIDTH-1:0]      sec_q, sec_d;
    logic [IDX_WIDTH-1:0]              idx_q, idx_d;
    logic [IDX_WIDTH-1:0]              sidx_q, sidx_d;
    logic [IDX_WIDTH-1:0]              k_q, k_d;

    logic                              rv_q, rv_d;
    logic [IDX_WIDTH-1:0]              cidx_q, cidx_d;
    logic signed [DATA_WIDTH-1:0]      mscore_q, mscore_d;
    logic [IDX_WIDTH-1:0]              ridx_q, ridx_d;
    logic [DATA_WIDTH-1:0]             margin_q, margin_d;
    logic                              lc_q, lc_d;
    logic [7:0]                        drop_q, drop_d;

    logic signed [DATA_WIDTH-1:0]      cur;
    logic [DATA_WIDTH:0]               diff;
    logic                              finish;

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (k_q == IDX_WIDTH'(i)) begin
                cur = scores_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        scores_d = scores_q;
        max_d    = max_q;
        sec_d    = sec_q;
        idx_d    = idx_q;
        sidx_d   = sidx_q;
        k_d      = k_q;
        rv_d     = rv_q;
        cidx_d   = cidx_q;
        mscore_d = mscore_q;
        ridx_d   = ridx_q;
        margin_d = margin_q;
        lc_d     = lc_q;
        drop_d   = drop_q;
        finish   = 1'b0;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (scores_valid) begin
                        scores_d = scores_in;
                        max_d    = scores_in[DATA_WIDTH-1:0];
                        idx_d    = '0;
                        sec_d    = MIN_SCORE;
                        sidx_d   = '0;
                        k_d      = IDX_WIDTH'(1);
                        state_d  = SCAN;
                        if (NUM_CLASSES == 1) begin
                            state_d = DONE;
                            finish  = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Strict compares keep the earlier index on ties
                    if (cur > max_q) begin
                        sec_d  = max_q;
                        sidx_d = idx_q;
                        max_d  = cur;
                        idx_d  = k_q;
                    end else if (cur > sec_q) begin
                        sec_d  = cur;
                        sidx_d = k_q;
                    end
                    k_d = k_q + 1'b1;
                    if (k_q == LAST_K) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_d = IDLE;
                        rv_d    = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (state_q != IDLE && scores_valid && drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end

        // One extra bit so the full signed span of max-second fits
        diff = {max_d[DATA_WIDTH-1], max_d} - {sec_d[DATA_WIDTH-1], sec_d};

        if (finish) begin
            rv_d     = 1'b1;
            cidx_d   = idx_d;
            mscore_d = max_d;
            ridx_d   = sidx_d;
            margin_d = diff[DATA_WIDTH-1:0];
            lc_d     = diff[DATA_WIDTH-1:0] < LOW_CONF_MARGIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            scores_q <= '0;
            max_q    <= '0;
            sec_q    <= '0;
            idx_q    <= '0;
            sidx_q   <= '0;
            k_q      <= '0;
            rv_q     <= 1'b0;
            cidx_q   <= '0;
            mscore_q <= '0;
            ridx_q   <= '0;
            margin_q <= '0;
            lc_q     <= 1'b1;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            scores_q <= scores_d;
            max_q    <= max_d;
            sec_q    <= sec_d;
            idx_q    <= idx_d;
            sidx_q   <= sidx_d;
            k_q      <= k_d;
            rv_q     <= rv_d;
            cidx_q   <= cidx_d;
            mscore_q <= mscore_d;
            ridx_q   <= ridx_d;
            margin_q <= margin_d;
            lc_q     <= lc_d;
            drop_q   <= drop_d;
        end
    end

    assign result_valid = rv_q;
    assign class_idx    = cidx_q;
    assign max_score    = mscore_q;
    assign second_idx   = ridx_q;
    assign margin       = margin_q;
    assign low_conf     = lc_q;
    assign busy         = state_q != IDLE;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_diagnosis_argmax.sv
// Directed bench for diagnosis_argmax: table of frames plus
// hand-written back-pressure, enable-stall and mid-scan reset sequences.
module tb_diagnosis_argmax;

    localparam int DW = 16;
    localparam int NC = 15;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [NC*DW-1:0] scores_in;
    logic             scores_valid;
    logic             result_ready;
    logic             result_valid;
    logic [IW-1:0]    class_idx;
    logic [DW-1:0]    max_score;
    logic [IW-1:0]    second_idx;
    logic [DW-1:0]    margin;
    logic             low_conf;
    logic             busy;
    logic [7:0]       drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    diagnosis_argmax dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .scores_in    (scores_in),
        .scores_valid (scores_valid),
        .result_ready (result_ready),
        .result_valid (result_valid),
        .class_idx    (class_idx),
        .max_score    (max_score),
        .second_idx   (second_idx),
        .margin       (margin),
        .low_conf     (low_conf),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    typedef struct {
        logic [NC*DW-1:0] sc;
        logic [IW-1:0]    idx;
        logic [DW-1:0]    mx;
        logic [IW-1:0]    sidx;
        logic [DW-1:0]    mg;
        logic             lc;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rv"}, 32'(result_valid), 32'd0);
        chk({tag, " idx"}, 32'(class_idx), 32'd0);
        chk({tag, " max"}, 32'(max_score), 32'd0);
        chk({tag, " sidx"}, 32'(second_idx), 32'd0);
        chk({tag, " margin"}, 32'(margin), 32'd0);
        chk({tag, " low_conf"}, 32'(low_conf), 32'd1);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " drop"}, 32'(drop_count), 32'd0);
    endtask

    task automatic chk_result(input vec_t v, input string tag);
        chk({tag, " rv"}, 32'(result_valid), 32'd1);
        chk({tag, " idx"}, 32'(class_idx), 32'(v.idx));
        chk({tag, " max"}, 32'(max_score), 32'(v.mx));
        chk({tag, " sidx"}, 32'(second_idx), 32'(v.sidx));
        chk({tag, " margin"}, 32'(margin), 32'(v.mg));
        chk({tag, " low_conf"}, 32'(low_conf), 32'(v.lc));
        chk({tag, " busy"}, 32'(busy), 32'd1);
    endtask

    task automatic start(input vec_t v);
        scores_in    = v.sc;
        scores_valid = 1'b1;
        tick();
        scores_valid = 1'b0;
    endtask

    task automatic wait_rv(output int lat);
        lat = 0;
        while (!result_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pre;
        logic [NC*DW-1:0] junk;

        for (int k = 0; k < NC; k++) begin
            vt[0].sc[k*DW +: DW] = DW'(k * 16);
            vt[1].sc[k*DW +: DW] = 16'h0100;
            vt[2].sc[k*DW +: DW] = (k == 7) ? 16'hFFF0 : 16'hFF00;
            vt[3].sc[k*DW +: DW] = DW'(1000 - k * 100);
            vt[4].sc[k*DW +: DW] = (k == 3) ? 16'h7FFF : 16'h8000;
            junk[k*DW +: DW]     = 16'h7FFF;
        end
        vt[0].idx = 4'd14; vt[0].mx = 16'd224;   vt[0].sidx = 4'd13;
        vt[0].mg  = 16'd16;    vt[0].lc = 1'b1;
        vt[1].idx = 4'd0;  vt[1].mx = 16'h0100;  vt[1].sidx = 4'd1;
        vt[1].mg  = 16'd0;     vt[1].lc = 1'b1;
        vt[2].idx = 4'd7;  vt[2].mx = 16'hFFF0;  vt[2].sidx = 4'd0;
        vt[2].mg  = 16'd240;   vt[2].lc = 1'b0;
        vt[3].idx = 4'd0;  vt[3].mx = 16'd1000;  vt[3].sidx = 4'd1;
        vt[3].mg  = 16'd100;   vt[3].lc = 1'b0;
        vt[4].idx = 4'd3;  vt[4].mx = 16'h7FFF;  vt[4].sidx = 4'd0;
        vt[4].mg  = 16'hFFFF;  vt[4].lc = 1'b0;

        rst = 1'b0; en = 1'b0; scores_in = '0;
        scores_valid = 1'b0; result_ready = 1'b1;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b1; en = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) begin
            start(vt[i]);
            chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
            wait_rv(lat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'd14);
            chk_result(vt[i], $sformatf("v%0d", i));
            tick();
            chk($sformatf("v%0d rv clear", i), 32'(result_valid), 32'd0);
            chk($sformatf("v%0d idle", i), 32'(busy), 32'd0);
        end
        chk("no drops", 32'(drop_count), 32'd0);

        // Back-pressure with ignored frames in SCAN and DONE
        result_ready = 1'b0;
        start(vt[0]);
        tick(); tick(); tick();
        scores_in    = junk;
        scores_valid = 1'b1;
        tick();
        scores_valid = 1'b0;
        wait_rv(lat);
        chk("bp latency", 32'(lat + 4), 32'd14);
        chk_result(vt[0], "bp first");
        for (int i = 0; i < 10; i++) begin
            scores_valid = (i == 2 || i == 6);
            tick();
            chk_result(vt[0], $sformatf("bp hold%0d", i));
        end
        scores_valid = 1'b0;
        chk("bp drops", 32'(drop_count), 32'd3);
        result_ready = 1'b1;
        tick();
        chk("bp rv clear", 32'(result_valid), 32'd0);
        chk("bp idle", 32'(busy), 32'd0);
        start(vt[2]);
        wait_rv(lat);
        chk("bp next latency", 32'(lat), 32'd14);
        chk_result(vt[2], "bp next");
        tick();

        // Enable stall mid-scan
        start(vt[3]);
        tick(); tick(); tick(); tick();
        pre = 4;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            scores_valid = (i == 1);
            tick();
            pre++;
            chk($sformatf("stall rv%0d", i), 32'(result_valid), 32'd0);
        end
        scores_valid = 1'b0;
        en = 1'b1;
        wait_rv(lat);
        chk("stall latency", 32'(lat + pre), 32'd19);
        chk_result(vt[3], "stall");
        chk("stall drops", 32'(drop_count), 32'd3);
        tick();

        // Reset at scan index 6, with enable low
        start(vt[1]);
        tick(); tick(); tick(); tick(); tick();
        en  = 1'b0;
        rst = 1'b0;
        tick();
        chk_reset("midrst");
        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 16; i++) tick();
        chk("midrst no result", 32'(result_valid), 32'd0);
        chk("midrst idle", 32'(busy), 32'd0);
        start(vt[4]);
        wait_rv(lat);
        chk("midrst latency", 32'(lat), 32'd14);
        chk_result(vt[4], "midrst new");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/diagnosis_argmax.md
DIAGNOSIS_ARGMAX -- requirements
Module: diagnosis_argmax

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: width of one signed fixed-point class score.
REQ-002 The block SHALL have parameter NUM_CLASSES, default 15: number of class scores per frame.
REQ-003 The block SHALL have parameter IDX_WIDTH, default 4: width of class index outputs.
REQ-004 The block SHALL have parameter LOW_CONF_MARGIN, default 16'h0040: margin threshold for the low-confidence flag.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port en, input, 1 bit: global enable; when low, all state SHALL hold.
REQ-008 The block SHALL have port scores_in, input, NUM_CLASSES*DATA_WIDTH bits: packed signed scores, class k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port scores_valid, input, 1 bit: scores_in is valid, driven by the upstream valid_out.
REQ-010 The block SHALL have port result_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result_valid, output, 1 bit: the result outputs are valid.
REQ-012 The block SHALL have port class_idx, output, IDX_WIDTH bits: index of the maximum score.
REQ-013 The block SHALL have port max_score, output, DATA_WIDTH bits, signed: the maximum score.
REQ-014 The block SHALL have port second_idx, output, IDX_WIDTH bits: index of the runner-up score.
REQ-015 The block SHALL have port margin, output, DATA_WIDTH bits, unsigned: max_score minus the runner-up score.
REQ-016 The block SHALL have port low_conf, output, 1 bit: high when margin < LOW_CONF_MARGIN.
REQ-017 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE.
REQ-018 The block SHALL have port drop_count, output, 8 bits: count of frames dropped while not IDLE; saturates at 255.

Function
REQ-019 The state machine SHALL have exactly three states: IDLE, SCAN and DONE; all transitions SHALL require en=1.
REQ-020 In IDLE, when scores_valid=1 the block SHALL perform a capture and enter SCAN. Capture consists of:
- register all scores;
- max=score[0], idx=0;
- second=-2^(DATA_WIDTH-1), second_idx=0;
- k=1.
REQ-021 In SCAN, each cycle SHALL process score[k] with a signed compare:
- if s>max: second=max, second_idx=idx, max=s, idx=k;
- else if s>second: second=s, second_idx=k;
- then k=k+1.
REQ-022 Ties SHALL keep the earlier index, because all compares are strict greater-than.
REQ-023 After processing k=NUM_CLASSES-1, the block SHALL enter DONE; result_valid SHALL rise exactly NUM_CLASSES-1 (14) enabled cycles after the capture edge.
REQ-024 margin SHALL equal max-second, computed at DATA_WIDTH+1 bits and presented as unsigned DATA_WIDTH bits (range 0..65535); no overflow is possible.
REQ-025 In DONE, result_valid and all result outputs SHALL stay stable until result_ready=1 is sampled; the block SHALL then return to IDLE, with result_valid=0 on the next cycle.
REQ-026 scores_valid SHALL be ignored while in SCAN or DONE, including the DONE handshake cycle; each such ignored cycle SHALL increment drop_count (saturating), and the captured scores SHALL be unaffected.
REQ-027 With en=0, all state SHALL hold: scan progress, outputs, drop_count and the pending result; scores_valid SHALL be neither captured nor counted.
REQ-028 With NUM_CLASSES=1, the block SHALL go from capture straight to DONE with margin = score[0]+2^(DATA_WIDTH-1).
REQ-029 Result outputs SHALL be registered; no combinational path SHALL exist from scores_in to any output.

Reset
REQ-030 When rst=0 at a rising edge, regardless of en, the block SHALL:
- enter IDLE;
- clear result_valid, class_idx, max_score, second_idx, margin, busy and drop_count to 0;
- set low_conf to 1.
REQ-031 A reset asserted during SCAN or DONE SHALL discard the frame with no result presented; the first enabled scores_valid after reset release SHALL be captured normally.

Verification
REQ-032 Ascending scores (score[k]=k*16), result_ready=1 -> result_valid 14 cycles after capture; class_idx=14, max_score=224, second_idx=13, margin=16, low_conf=1.
REQ-033 All scores 16'h0100 -> class_idx=0, second_idx=1, margin=0, low_conf=1.
REQ-034 Negative scores (all 16'hFF00 except score[7]=16'hFFF0) -> class_idx=7, max_score=-16, second_idx=0, margin=240, low_conf=0.
REQ-035 result_ready=0 for 10 cycles in DONE, with scores_valid pulsed 3 times during SCAN and DONE -> outputs stable throughout, drop_count=3; after the handshake, the next frame is captured.
REQ-036 en=0 for 5 cycles in mid-SCAN -> result_valid delayed by exactly 5 cycles; result values unchanged.
REQ-037 rst=0 at SCAN k=6 -> IDLE, all outputs at reset values; a new frame afterwards gives a correct result.
